branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Sequences control-flow changes in the RV32I pipeline. The block consumes the EX-stage branch outcome (conditional branch decision, JAL, JALR) and a computed target. It drives a handshaked PC redirect to the fetch stage, squashes wrong-path instructions in IF/ID and ID/EX, and raises an instruction-address-misaligned trap. The pipeline uses static not-taken prediction: every taken branch and every jump costs a redirect. The block also keeps branch statistics counters.

## Interface
Parameters:
- XLEN, 32, address/data width
- CNT_W, 32, width of each statistics counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX stage holds a valid (non-bubble) instruction
- ex_opcode  in  7  opcode of the EX instruction
- ex_pc  in  XLEN  PC of the EX instruction
- ex_target  in  XLEN  computed target (pc+imm or rs1+imm)
- branch_taken  in  1  conditional-branch decision for the EX instruction
- bolha  in  1  load-use stall: EX contents are frozen/not final this cycle
- fetch_ready  in  1  fetch stage accepts the redirect this cycle
- trap_ack  in  1  trap handler has taken the trap
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  XLEN  new fetch PC
- flush_ifid  out  1  squash IF/ID register
- flush_idex  out  1  squash ID/EX register
- trap_valid  out  1  instruction-address-misaligned trap pending
- trap_pc  out  XLEN  PC of the faulting control-flow instruction
- trap_tval  out  XLEN  offending (misaligned) target
- busy  out  1  state != IDLE
- cnt_branch  out  CNT_W  conditional branches resolved
- cnt_taken  out  CNT_W  conditional branches taken
- cnt_redirect  out  CNT_W  redirects issued

## Operation
- Opcode decode:
  - BRANCH = 1100011.
  - JAL = 1101111.
  - JALR = 1100111.
- Resolve cycle: state==IDLE & ex_valid & !bolha. There is no resolution in any other case.
- Control-flow event: a resolve cycle where the opcode is JAL, or JALR, or BRANCH with branch_taken=1.
- Effective target (tgt):
  - JALR: {ex_target[XLEN-1:1],1'b0}.
  - Otherwise: ex_target.
- Misaligned event: tgt[1:0] != 0. The JALR bit 0 is already cleared, so for JALR only bit 1 matters.
- FSM states: IDLE, REDIRECT, TRAP.
  - IDLE → REDIRECT on an aligned control-flow event. Latch redirect_pc=tgt. cnt_redirect += 1.
  - IDLE → TRAP on a misaligned event. Latch trap_pc=ex_pc and trap_tval=tgt. No redirect is issued.
  - REDIRECT → IDLE when fetch_ready=1. Otherwise hold; redirect_pc stays stable.
  - TRAP → IDLE when trap_ack=1. Otherwise hold.
- Outputs by state (all combinational from state; no input-to-output path):
  - redirect_valid = (state==REDIRECT).
  - trap_valid = (state==TRAP).
  - flush_ifid = flush_idex = (state != IDLE).
- Events arriving in REDIRECT or TRAP are ignored. The instructions behind them are wrong-path and are being flushed.
- bolha only gates resolution. It does not stall the REDIRECT or TRAP handshakes.
- Counters, updated only in resolve cycles (counters wrap modulo 2^CNT_W, no saturation):
  - cnt_branch += 1 when opcode==BRANCH.
  - cnt_taken += 1 when opcode==BRANCH & branch_taken, including misaligned taken branches.
- Non-control-flow opcodes have no effect.
- Reset values: state=IDLE; redirect_pc, trap_pc, trap_tval = 0; all counters = 0; therefore all valid, flush and busy outputs = 0.
- Reset mid-REDIRECT or mid-TRAP drops the request immediately (asynchronously).

## Timing
- Event sampled at the edge closing cycle N. In cycle N+1: redirect_valid=1, flushes=1, busy=1.
- fetch_ready=1 in N+1 → IDLE in N+2. A new resolution can be accepted in N+2.
- Minimum redirect penalty: 1 controller cycle. Each extra cycle with fetch_ready=0 adds one cycle. Flushes stay asserted for the whole of REDIRECT.
- Trap follows the same timing, with trap_ack in place of fetch_ready.
- Counter update is visible in cycle N+1.
- fetch_ready and trap_ack are ignored outside their respective states.

## Test plan
- Reset, then BRANCH with branch_taken=0, ex_valid=1, bolha=0 → no redirect; cnt_branch=1, cnt_taken=0, busy=0.
- BRANCH taken, ex_target=0x0000_0100, fetch_ready=1 → one cycle of redirect_valid=1, redirect_pc=0x100, flush_ifid=flush_idex=1; cnt_taken=1, cnt_redirect=1; IDLE next cycle.
- JAL to 0x200 with fetch_ready=0 for 3 cycles, then 1 → redirect_valid held 4 cycles with redirect_pc=0x200 constant. A taken BRANCH presented during those cycles is not counted and does not retarget.
- JALR with ex_target=0x0000_0105 → redirect_pc=0x104. JALR with ex_target=0x0000_0106 → TRAP: trap_valid=1, trap_pc=ex_pc, trap_tval=0x106, flushes=1, held until trap_ack, cnt_redirect unchanged.
- Taken BRANCH with bolha=1 for 2 cycles, then bolha=0 → no action or count while stalled; redirect begins the cycle after bolha drops; cnt_branch increments exactly once.
- rst_n low mid-REDIRECT → redirect_valid, flushes and counters go to 0 immediately. With CNT_W=4, 16 resolved branches → cnt_branch wraps to 0.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Resolves EX-stage control flow under static not-taken prediction: issues a
// handshaked PC redirect to fetch, squashes the wrong-path IF/ID and ID/EX
// contents, raises an instruction-address-misaligned trap, and keeps branch
// statistics. All valid/flush/busy outputs are registered flags that track
// the FSM state, so there is no input-to-output combinational path.
module branch_redirect_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic [6:0]       ex_opcode,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_target,
   input  logic             branch_taken,
   input  logic             bolha,
   input  logic             fetch_ready,
   input  logic             trap_ack,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush_ifid,
   output logic             flush_idex,
   output logic             trap_valid,
   output logic [XLEN-1:0]  trap_pc,
   output logic [XLEN-1:0]  trap_tval,
   output logic             busy,
   output logic [CNT_W-1:0] cnt_branch,
   output logic [CNT_W-1:0] cnt_taken,
   output logic [CNT_W-1:0] cnt_redirect
);

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      TRAP     = 2'd2
   } state_t;

   state_t            state_r;
   logic              redirect_valid_r;
   logic              trap_valid_r;
   logic              flush_r;
   logic [XLEN-1:0]   redirect_pc_r;
   logic [XLEN-1:0]   trap_pc_r;
   logic [XLEN-1:0]   trap_tval_r;
   logic [CNT_W-1:0]  cnt_branch_r;
   logic [CNT_W-1:0]  cnt_taken_r;
   logic [CNT_W-1:0]  cnt_redirect_r;

   logic              resolve_s;
   logic              is_branch_s;
   logic              is_jal_s;
   logic              is_jalr_s;
   logic              cf_event_s;
   logic              misaligned_s;
   logic [XLEN-1:0]   tgt_s;

   // Decode the EX instruction and form the effective target and event flags
   always_comb begin
      is_branch_s  = (ex_opcode == OP_BRANCH);
      is_jal_s     = (ex_opcode == OP_JAL);
      is_jalr_s    = (ex_opcode == OP_JALR);
      resolve_s    = (state_r == IDLE) && ex_valid && !bolha;
      tgt_s        = ex_target;
      if (is_jalr_s) begin
         // JALR ignores bit 0 of the computed address
         tgt_s = {ex_target[XLEN-1:1], 1'b0};
      end else begin
         tgt_s = ex_target;
      end
      cf_event_s   = resolve_s && (is_jal_s || is_jalr_s || (is_branch_s && branch_taken));
      misaligned_s = (tgt_s[1:0] != 2'b00);
   end

   // Redirect/trap FSM with registered request, flush and captured addresses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r          <= IDLE;
         redirect_valid_r <= 1'b0;
         trap_valid_r     <= 1'b0;
         flush_r          <= 1'b0;
         redirect_pc_r    <= '0;
         trap_pc_r        <= '0;
         trap_tval_r      <= '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cf_event_s) begin
                  flush_r <= 1'b1;
                  if (misaligned_s) begin
                     state_r      <= TRAP;
                     trap_valid_r <= 1'b1;
                     trap_pc_r    <= ex_pc;
                     trap_tval_r  <= tgt_s;
                  end else begin
                     state_r          <= REDIRECT;
                     redirect_valid_r <= 1'b1;
                     redirect_pc_r    <= tgt_s;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            REDIRECT: begin
               if (fetch_ready) begin
                  state_r          <= IDLE;
                  redirect_valid_r <= 1'b0;
                  flush_r          <= 1'b0;
               end else begin
                  state_r <= REDIRECT;
               end
            end
            TRAP: begin
               if (trap_ack) begin
                  state_r      <= IDLE;
                  trap_valid_r <= 1'b0;
                  flush_r      <= 1'b0;
               end else begin
                  state_r <= TRAP;
               end
            end
            default: begin
               state_r          <= IDLE;
               redirect_valid_r <= 1'b0;
               trap_valid_r     <= 1'b0;
               flush_r          <= 1'b0;
            end
         endcase
      end
   end

   // Branch statistics, advanced only in resolve cycles, wrapping on overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_branch_r   <= '0;
         cnt_taken_r    <= '0;
         cnt_redirect_r <= '0;
      end else begin
         if (resolve_s && is_branch_s) begin
            cnt_branch_r <= cnt_branch_r + CNT_W'(1);
            if (branch_taken) begin
               cnt_taken_r <= cnt_taken_r + CNT_W'(1);
            end else begin
               cnt_taken_r <= cnt_taken_r;
            end
         end else begin
            cnt_branch_r <= cnt_branch_r;
            cnt_taken_r  <= cnt_taken_r;
         end
         if (cf_event_s && !misaligned_s) begin
            cnt_redirect_r <= cnt_redirect_r + CNT_W'(1);
         end else begin
            cnt_redirect_r <= cnt_redirect_r;
         end
      end
   end

   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;
   assign trap_valid     = trap_valid_r;
   assign trap_pc        = trap_pc_r;
   assign trap_tval      = trap_tval_r;
   assign flush_ifid     = flush_r;
   assign flush_idex     = flush_r;
   assign busy           = flush_r;
   assign cnt_branch     = cnt_branch_r;
   assign cnt_taken      = cnt_taken_r;
   assign cnt_redirect   = cnt_redirect_r;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Testbench for branch_redirect_ctrl: random and directed control-flow
// traffic, a spec-level reference model, and a scoreboard monitor that checks
// every redirect/trap handshake plus the per-cycle flags and counters.
module tb_branch_redirect_ctrl;

   localparam int XLEN = 32;
   localparam int CW   = 4;
   localparam int MOD  = 1 << CW;

   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] ALU  = 7'b0110011;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ex_valid = 1'b0;
   logic [6:0]      ex_opcode = 7'd0;
   logic [XLEN-1:0] ex_pc = 32'd0;
   logic [XLEN-1:0] ex_target = 32'd0;
   logic            branch_taken = 1'b0;
   logic            bolha = 1'b0;
   logic            fetch_ready = 1'b0;
   logic            trap_ack = 1'b0;
   logic            redirect_valid, flush_ifid, flush_idex, trap_valid, busy;
   logic [XLEN-1:0] redirect_pc, trap_pc, trap_tval;
   logic [CW-1:0]   cnt_branch, cnt_taken, cnt_redirect;

   branch_redirect_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_pc(ex_pc), .ex_target(ex_target), .branch_taken(branch_taken),
      .bolha(bolha), .fetch_ready(fetch_ready), .trap_ack(trap_ack),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex),
      .trap_valid(trap_valid), .trap_pc(trap_pc), .trap_tval(trap_tval),
      .busy(busy), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken),
      .cnt_redirect(cnt_redirect)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct { bit is_trap; int unsigned pc; int unsigned tval; } exp_t;
   exp_t exp_q[$];

   // Reference model: pending request kind (0 none, 1 redirect, 2 trap)
   int m_pending = 0;
   int m_branches = 0;
   int m_taken = 0;
   int m_redirects = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: apply the resolution rules to the inputs seen at each rising edge
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pending = 0; m_branches = 0; m_taken = 0; m_redirects = 0;
            exp_q.delete();
         end else if (m_pending == 0) begin
            if (ex_valid && !bolha) begin
               bit cf;
               int unsigned tgt;
               if (ex_opcode == BR) begin
                  m_branches = (m_branches + 1) % MOD;
                  if (branch_taken) m_taken = (m_taken + 1) % MOD;
               end
               cf = (ex_opcode == JAL) || (ex_opcode == JALR) || (ex_opcode == BR && branch_taken);
               if (cf) begin
                  tgt = ex_target;
                  if (ex_opcode == JALR) tgt = (tgt / 2) * 2;
                  if (tgt % 4 != 0) begin
                     m_pending = 2;
                     exp_q.push_back('{1'b1, ex_pc, tgt});
                  end else begin
                     m_pending = 1;
                     m_redirects = (m_redirects + 1) % MOD;
                     exp_q.push_back('{1'b0, tgt, 0});
                  end
               end
            end
         end else if (m_pending == 1 && fetch_ready) begin
            m_pending = 0;
         end else if (m_pending == 2 && trap_ack) begin
            m_pending = 0;
         end
      end
   end

   // Monitor: mid-cycle checks of flags, counters and scoreboard handshakes
   initial begin
      forever begin
         @(negedge clk);
         chk("busy", busy, m_pending != 0);
         chk("flush_ifid", flush_ifid, m_pending != 0);
         chk("flush_idex", flush_idex, m_pending != 0);
         chk("redirect_valid", redirect_valid, m_pending == 1);
         chk("trap_valid", trap_valid, m_pending == 2);
         chk("cnt_branch", 32'(cnt_branch), m_branches);
         chk("cnt_taken", 32'(cnt_taken), m_taken);
         chk("cnt_redirect", 32'(cnt_redirect), m_redirects);
         if (redirect_valid || trap_valid) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_empty", 32'd1, 32'd0);
            end else if (redirect_valid) begin
               chk("redir_kind", 32'(exp_q[0].is_trap), 32'd0);
               chk("redirect_pc", redirect_pc, exp_q[0].pc);
               if (fetch_ready) void'(exp_q.pop_front());
            end else begin
               chk("trap_kind", 32'(exp_q[0].is_trap), 32'd1);
               chk("trap_pc", trap_pc, exp_q[0].pc);
               chk("trap_tval", trap_tval, exp_q[0].tval);
               if (trap_ack) void'(exp_q.pop_front());
            end
         end
      end
   end

   // One cycle of stimulus, applied shortly after the rising edge
   task automatic drive(input bit v, input logic [6:0] op, input logic [31:0] pc,
                        input logic [31:0] tgt, input bit tk, input bit bl,
                        input bit fr, input bit ack);
      @(posedge clk); #3;
      ex_valid = v; ex_opcode = op; ex_pc = pc; ex_target = tgt;
      branch_taken = tk; bolha = bl; fetch_ready = fr; trap_ack = ack;
   endtask

   initial begin
      #1;
      chk("reset_redirect_valid", redirect_valid, 1'b0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      chk("reset_trap_pc", trap_pc, 32'd0);
      chk("reset_busy", busy, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      // Not-taken branch, then taken branch accepted immediately
      drive(1, BR, 32'h40, 32'h100, 0, 0, 1, 0);
      drive(1, BR, 32'h44, 32'h100, 1, 0, 1, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 0);
      // JAL held by fetch for 3 cycles while a taken branch is presented
      drive(1, JAL, 32'h48, 32'h200, 0, 0, 0, 0);
      drive(1, BR, 32'h4c, 32'h300, 1, 0, 0, 0);
      drive(1, BR, 32'h50, 32'h300, 1, 0, 0, 0);
      drive(1, BR, 32'h54, 32'h300, 1, 0, 1, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 0);
      // JALR aligned after clearing bit 0, then misaligned JALR trap held
      drive(1, JALR, 32'h60, 32'h105, 0, 0, 1, 0);
      drive(1, JALR, 32'h64, 32'h106, 0, 0, 1, 0);
      drive(1, JAL, 32'h68, 32'h400, 0, 0, 1, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 1);
      // Taken branch stalled by bolha for two cycles
      drive(1, BR, 32'h70, 32'h500, 1, 1, 1, 0);
      drive(1, BR, 32'h70, 32'h500, 1, 1, 1, 0);
      drive(1, BR, 32'h70, 32'h500, 1, 0, 1, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 0);
      // Sixteen not-taken branches wrap the branch counter
      for (int i = 0; i < 16; i++) drive(1, BR, 32'h80 + 32'(4 * i), 32'h0, 0, 0, 1, 0);
      drive(1, ALU, 32'h0, 32'h0, 0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [6:0]  op;
         logic [31:0] tgt;
         int sel;
         sel = $urandom_range(0, 3);
         op = (sel == 0) ? BR : (sel == 1) ? JAL : (sel == 2) ? JALR : ALU;
         tgt = $urandom;
         if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
         if (op == JALR && $urandom_range(0, 1) == 1) tgt[0] = 1'b1;
         drive($urandom_range(0, 9) < 7, op, $urandom & 32'hffff_fffc, tgt,
               $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);
      end

      // Reset asserted in the middle of a stalled redirect
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 1);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 1);
      drive(1, JAL, 32'h90, 32'h600, 0, 0, 0, 0);
      drive(0, ALU, 32'h0, 32'h0, 0, 0, 0, 0);
      #1;
      chk("pre_reset_redirect", redirect_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async_redirect_valid", redirect_valid, 1'b0);
      chk("async_flush_ifid", flush_ifid, 1'b0);
      chk("async_flush_idex", flush_idex, 1'b0);
      chk("async_cnt_redirect", 32'(cnt_redirect), 32'd0);
      chk("async_cnt_branch", 32'(cnt_branch), 32'd0);
      chk("async_redirect_pc", redirect_pc, 32'd0);
      @(posedge clk); #3 rst_n = 1'b1;
      drive(1, BR, 32'ha0, 32'h700, 1, 0, 1, 0);
      repeat (3) drive(0, ALU, 32'h0, 32'h0, 0, 0, 1, 1);
      @(negedge clk); #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
